// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_loader                                                   |
// | Brief    : byte-stream program loader; packs bytes big-endian into WIDTH |
// |            bit words for the instruction memory write port. Define       |
// |            IMEM_LOADER_CHECKSUM_EN for a trailing 8-bit checksum byte.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_loader #(
    parameter int WIDTH  = 24,
    parameter int AMOUNT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(AMOUNT):0]   word_count,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic [3:0]                mem_we,
    output logic [WIDTH-1:0]          mem_a,
    output logic [WIDTH-1:0]          mem_wd,
    output logic                      busy,
    output logic                      done,
    output logic                      cpu_hold,
    output logic                      err
);

    localparam int c_bpw    = WIDTH / 8;
    localparam int c_addr_w = $clog2(AMOUNT);
    localparam int c_bc_w   = (c_bpw > 1) ? $clog2(c_bpw) : 1;

    localparam logic [c_addr_w:0]   c_amount    = (c_addr_w + 1)'(AMOUNT);
    localparam logic [c_addr_w:0]   c_cnt_one   = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_addr_one  = c_addr_w'(1);
    localparam logic [c_bc_w-1:0]   c_bc_one    = c_bc_w'(1);
    localparam logic [c_bc_w-1:0]   c_last_byte = c_bc_w'(c_bpw - 1);

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_recv  = 3'd1;
    localparam logic [2:0] c_s_write = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_s_check = 3'd3;
`endif
    localparam logic [2:0] c_s_done  = 3'd4;

    logic [2:0]          r_state;
    logic [c_addr_w:0]   r_cnt;
    logic [c_addr_w-1:0] r_addr;
    logic [c_bc_w-1:0]   r_byte_cnt;
    logic [WIDTH-1:0]    r_word;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [c_addr_w-1:0] r_mem_a;
    logic [WIDTH-1:0]    r_mem_wd;
    logic                r_busy;
    logic                r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic                r_err;
`endif

    logic                w_accept;
    logic [c_addr_w:0]   w_clamped;
    logic                w_last_word;
    logic [WIDTH-1:0]    w_word_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_clamped   = (word_count > c_amount) ? c_amount : word_count;
    assign w_last_word = (({1'b0, r_addr} + c_cnt_one) == r_cnt);
    // Oldest byte falls off the top; the newest lands in the low byte.
    assign w_word_next = WIDTH'({r_word, in_data});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_s_idle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_a    <= '0;
            r_mem_wd   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_s_idle, c_s_done: begin
                    if (start) begin
                        r_cnt      <= w_clamped;
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum      <= '0;
                        r_err      <= 1'b0;
`endif
                        if (w_clamped == '0) begin
                            r_state    <= c_s_done;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state    <= c_s_recv;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                c_s_recv: begin
                    if (w_accept) begin
                        r_word <= w_word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum  <= r_sum + in_data;
`endif
                        if (r_byte_cnt == c_last_byte) begin
                            // Strobe is registered here so it appears during WRITE.
                            r_byte_cnt <= '0;
                            r_state    <= c_s_write;
                            r_in_ready <= 1'b0;
                            r_mem_we   <= 1'b1;
                            r_mem_a    <= r_addr;
                            r_mem_wd   <= w_word_next;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_bc_one;
                        end
                    end
                end
                c_s_write: begin
                    if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state    <= c_s_check;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= c_s_done;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else begin
                        r_addr     <= r_addr + c_addr_one;
                        r_state    <= c_s_recv;
                        r_in_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                c_s_check: begin
                    if (w_accept) begin
                        r_err      <= (in_data != r_sum);
                        r_state    <= c_s_done;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state    <= c_s_idle;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign mem_we   = {3'b000, r_mem_we};
    assign mem_a    = {{(WIDTH - c_addr_w){1'b0}}, r_mem_a};
    assign mem_wd   = r_mem_wd;
    assign busy     = r_busy;
    assign cpu_hold = r_busy;
    assign done     = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err      = r_err;
`else
    assign err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_loader                                                |
// | Brief    : self-checking bench for imem_loader (WIDTH=24, AMOUNT=64)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  mem_we;
    logic [23:0] mem_a;
    logic [23:0] mem_wd;
    logic        busy, done, cpu_hold, err;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit c_cs = 1'b1;
`else
    localparam bit c_cs = 1'b0;
`endif

    imem_loader #(.WIDTH(24), .AMOUNT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writes observed on the memory port, in order.
    logic [31:0] log_a [0:255];
    logic [23:0] log_d [0:255];
    int          log_n = 0;

    // Transaction-level model: phase 0 = idle/done, 1 = receiving words, 2 = awaiting checksum.
    bit          model_on  = 1'b0;
    int          m_phase   = 0;
    int          m_left    = 0;
    int          m_addr    = 0;
    int          m_nb      = 0;
    logic [23:0] m_word    = '0;
    logic [23:0] m_pword   = '0;
    bit          m_pending = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    logic [7:0]  m_sum     = '0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("cpu_hold", 32'(cpu_hold), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("in_ready", 32'(in_ready), 32'(m_phase != 0 && !m_pending));
            chk("err", 32'(err), 32'(m_err));
            if (m_pending) begin
                chk("mem_we", 32'(mem_we), 32'h1);
                chk("mem_a", 32'(mem_a), 32'(m_addr));
                chk("mem_wd", 32'(mem_wd), 32'(m_pword));
            end else begin
                chk("mem_we_idle", 32'(mem_we), 32'h0);
            end
            if (mem_we !== 4'h0 && log_n < 256) begin
                log_a[log_n] = 32'(mem_a);
                log_d[log_n] = mem_wd;
                log_n++;
            end
        end
        if (rst) begin
            model_on  = 1'b1;
            m_phase   = 0;
            m_pending = 1'b0;
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_nb      = 0;
        end else if (model_on) begin
            if (m_pending) begin
                m_pending = 1'b0;
                m_addr++;
                if (m_addr == m_left) begin
                    m_phase = c_cs ? 2 : 0;
                    if (!c_cs) m_done = 1'b1;
                end
            end else if (start && m_phase == 0) begin
                m_left  = (word_count > 7'd64) ? 64 : int'(word_count);
                m_addr  = 0;
                m_nb    = 0;
                m_sum   = '0;
                m_err   = 1'b0;
                m_done  = (m_left == 0);
                m_phase = (m_left == 0) ? 0 : 1;
            end else if (in_valid && m_phase == 1) begin
                m_word = {m_word[15:0], in_data};
                m_sum  = m_sum + in_data;
                m_nb++;
                if (m_nb == 3) begin
                    m_nb      = 0;
                    m_pending = 1'b1;
                    m_pword   = m_word;
                end
            end else if (in_valid && m_phase == 2) begin
                m_err   = (in_data != m_sum);
                m_phase = 0;
                m_done  = 1'b1;
            end
        end
    end

    task automatic pulse_start(input logic [6:0] wc);
        start = 1'b1;
        word_count = wc;
        @(posedge clk); #1;
        start = 1'b0;
        word_count = 7'h55;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  guard = 0;
        bit  taken = 1'b0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!taken && guard < 200) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!taken) chk("byte_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        @(negedge clk);
        while (!done && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(done), 32'h1);
        @(posedge clk); #1;
    endtask

    logic [7:0] stream [0:5];
    int         base;
    int         max_a;

    initial begin
        stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'h56;
        stream[3] = 8'hAB; stream[4] = 8'hCD; stream[5] = 8'hEF;
        rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_a", 32'(mem_a), 32'h0);
        chk("rst_mem_wd", 32'(mem_wd), 32'h0);
        chk("rst_busy_hold_done_err", 32'({busy, cpu_hold, done, err}), 32'h0);
        @(posedge clk); #1;

        // Empty load completes immediately with no write.
        base = log_n;
        pulse_start(7'd0);
        @(negedge clk);
        chk("zero_count_done", 32'(done), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("zero_count_writes", 32'(log_n - base), 32'h0);

        // Two words, back-to-back bytes.
        base = log_n;
        pulse_start(7'd2);
        for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
        if (c_cs) send_byte(8'h00, 1'b0);
        wait_done("b2b_done");
        chk("b2b_count", 32'(log_n - base), 32'h2);
        chk("b2b_w0_a", log_a[base], 32'h0);
        chk("b2b_w0_d", 32'(log_d[base]), 32'h123456);
        chk("b2b_w1_a", log_a[base + 1], 32'h1);
        chk("b2b_w1_d", 32'(log_d[base + 1]), 32'hABCDEF);
        chk("b2b_idle_hold", 32'({busy, cpu_hold}), 32'h0);

        // Bytes arriving in DONE are left on the link.
        in_valid = 1'b1; in_data = 8'h99;
        repeat (3) begin
            @(negedge clk);
            chk("done_no_ready", 32'(in_ready), 32'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Same stream with random gaps and an ignored mid-load start.
        base = log_n;
        pulse_start(7'd2);
        for (int i = 0; i < 6; i++) begin
            send_byte(stream[i], 1'b1);
            if (i == 1 || i == 2) pulse_start(7'd0);
        end
        if (c_cs) send_byte(8'h00, 1'b1);
        wait_done("rnd_done");
        chk("rnd_count", 32'(log_n - base), 32'h2);
        chk("rnd_w0_d", 32'(log_d[base]), 32'h123456);
        chk("rnd_w1_d", 32'(log_d[base + 1]), 32'hABCDEF);

        // Over-range count clamps to the memory depth.
        base = log_n;
        pulse_start(7'd100);
        for (int i = 0; i < 192; i++) send_byte(8'(i), 1'b0);
        if (c_cs) send_byte(8'h00, 1'b0);
        wait_done("clamp_done");
        chk("clamp_count", 32'(log_n - base), 32'd64);
        max_a = 0;
        for (int i = base; i < log_n; i++) if (int'(log_a[i]) > max_a) max_a = int'(log_a[i]);
        chk("clamp_max_addr", 32'(max_a), 32'd63);
        chk("clamp_first_d", 32'(log_d[base]), 32'h000102);
        chk("clamp_last_d", 32'(log_d[base + 63]), 32'hBDBEBF);

        // Reset in the middle of the second word.
        base = log_n;
        pulse_start(7'd2);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 32'({busy, done, in_ready, cpu_hold}), 32'h0);
        chk("midrst_count", 32'(log_n - base), 32'h1);
        chk("midrst_w0", {log_a[base][7:0], log_d[base]}, 32'h00112233);
        @(posedge clk); #1;
        pulse_start(7'd1);
        send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0);
        if (c_cs) send_byte(8'h12, 1'b0);
        wait_done("fresh_done");
        chk("fresh_count", 32'(log_n - base), 32'h2);
        chk("fresh_w", {log_a[base + 1][7:0], log_d[base + 1]}, 32'h00556677);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start(7'd1);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h06, 1'b0);
        wait_done("cs_ok_done");
        chk("cs_ok_err", 32'(err), 32'h0);
        pulse_start(7'd1);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h07, 1'b0);
        wait_done("cs_bad_done");
        chk("cs_bad_err", 32'(err), 32'h1);
`else
        chk("no_cs_err", 32'(err), 32'h0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
